layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/recon_pkg.sv | 32 +++
 rtl/syn_map.sv | 54 +++++
 rtl/layer_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recon_pkg.sv
// Shared types and widths for the layer sequencer and its synapse mapper.
package recon_pkg;

   // Width of each field in a stored layer configuration entry. Wide enough for
   // any realistic NUM_INPUTS / NUM_NEURONS; callers size-cast into it.
   localparam int CFG_W   = 8;

   // Width of the sequencer state encoding.
   localparam int STATE_W = 3;

   // Sequencer states: a run walks IDLE -> (MAP -> FIRE -> WAIT) per layer,
   // then DONE for the result strobe, then back to IDLE.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_MAP  = 3'd1,
      ST_FIRE = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // One entry of the per-layer configuration table.
   typedef struct packed {
      logic [CFG_W-1:0] ni;   // input lines used by this layer
      logic [CFG_W-1:0] nn;   // neurons used by this layer
   } layer_cfg_t;

   // True when 1 <= v <= hi.
   function automatic logic in_range(input int unsigned v, input int unsigned hi);
      return (v >= 32'd1) && (v <= hi);
   endfunction

endpackage

// File: rtl/syn_map.sv
// Combinational synapse mapper: lays out a layer of ni inputs by nn neurons
// onto the flat synapse array, neuron-major (synapse m = neuron*ni + input).
module syn_map
   import recon_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_NEURONS = 4,
   parameter int NUM_SYNAPSE = 16,
   localparam int NIW = $clog2(NUM_INPUTS) + 1,
   localparam int SNW = $clog2(NUM_NEURONS)
) (
   input  logic [CFG_W-1:0]                  i_ni,
   input  logic [CFG_W-1:0]                  i_nn,
   input  logic [NUM_INPUTS-1:0]             i_x_cur,
   output logic [NUM_SYNAPSE-1:0][NIW-1:0]   o_sel_ip,
   output logic [NUM_SYNAPSE-1:0]            o_syn_en,
   output logic [NUM_SYNAPSE-1:0]            o_syn_in,
   output logic [NUM_SYNAPSE-1:0][SNW-1:0]   o_syn_neuron
);

   int idx;
   int nrn;
   int lim;

   // Per synapse: active synapses get input index, owning neuron and the spike
   // on their selected input; unused synapses park on the out-of-range input
   // NUM_INPUTS so downstream muxes select nothing.
   always_comb begin
      idx          = 0;
      nrn          = 0;
      lim          = int'(i_ni) * int'(i_nn);
      o_sel_ip     = '0;
      o_syn_en     = '0;
      o_syn_in     = '0;
      o_syn_neuron = '0;
      for (int m = 0; m < NUM_SYNAPSE; m++) begin
         idx             = 0;
         nrn             = 0;
         o_sel_ip[m]     = NIW'(NUM_INPUTS);
         o_syn_en[m]     = 1'b0;
         o_syn_in[m]     = 1'b0;
         o_syn_neuron[m] = '0;
         if ((i_ni != '0) && (m < lim)) begin
            idx             = m % int'(i_ni);
            nrn             = m / int'(i_ni);
            o_sel_ip[m]     = NIW'(idx);
            o_syn_en[m]     = 1'b1;
            o_syn_in[m]     = |(i_x_cur & (NUM_INPUTS'(1) << idx));
            o_syn_neuron[m] = SNW'(nrn);
         end
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: runs a multi-layer spiking network on a shared synapse
// array. Each layer is mapped onto the synapses from a small config table,
// the array is fired, and its neuron spikes become the next layer's inputs.
module layer_sequencer
   import recon_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_NEURONS = 4,
   parameter int NUM_SYNAPSE = 16,
   parameter int NUM_LAYERS  = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   // configuration table write port
   input  logic                                                   cfg_we,
   input  logic [$clog2(NUM_LAYERS)-1:0]                          cfg_addr,
   input  logic [$clog2(NUM_INPUTS):0]                            cfg_ni,
   input  logic [$clog2(NUM_NEURONS):0]                           cfg_nn,
   // run control
   input  logic [$clog2(NUM_LAYERS):0]                            num_layers,
   input  logic                                                   start,
   input  logic [NUM_INPUTS-1:0]                                  x_in,
   // synapse mapping (registered)
   output logic [NUM_SYNAPSE-1:0][$clog2(NUM_INPUTS):0]           sel_ip,
   output logic [NUM_SYNAPSE-1:0]                                 syn_en,
   output logic [NUM_SYNAPSE-1:0]                                 syn_in,
   output logic [NUM_SYNAPSE-1:0][$clog2(NUM_NEURONS)-1:0]        syn_neuron,
   // array handshake
   output logic                                                   arr_start,
   input  logic                                                   arr_done,
   input  logic [NUM_NEURONS-1:0]                                 arr_spikes,
   // status / result
   output logic                                                   busy,
   output logic                                                   y_valid,
   output logic [NUM_NEURONS-1:0]                                 y_out,
   output logic                                                   cfg_err,
   output logic                                                   timeout_err,
   // current FSM state, for debug and checkers
   output logic [STATE_W-1:0]                                     dbg_state
);

   localparam int NIW = $clog2(NUM_INPUTS) + 1;
   localparam int NLW = $clog2(NUM_LAYERS) + 1;
   localparam int AW  = $clog2(NUM_LAYERS);
   localparam int SNW = $clog2(NUM_NEURONS);
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam int XN  = (NUM_INPUTS < NUM_NEURONS) ? NUM_INPUTS : NUM_NEURONS;

   // Parking value for an unused synapse: select the non-existent input.
   localparam logic [NUM_SYNAPSE-1:0][NIW-1:0] SEL_IDLE = {NUM_SYNAPSE{NIW'(NUM_INPUTS)}};

   // Array handshake: arr_start is a single-cycle request issued from FIRE;
   // the array answers later with a single-cycle arr_done carrying arr_spikes.
   // arr_done is only honoured in WAIT, so a done seen in the FIRE cycle
   // (stale from a previous evaluation) is dropped.

   state_t                              r_state;
   layer_cfg_t                          r_tab [NUM_LAYERS];
   logic [NLW-1:0]                      r_k;
   logic [NLW-1:0]                      r_nl;
   logic [NUM_INPUTS-1:0]               r_x_cur;
   logic [CFG_W-1:0]                    r_cur_nn;
   logic [WDW-1:0]                      r_wd;
   logic [NUM_NEURONS-1:0]              r_y_out;
   logic                                r_cfg_err;
   logic                                r_to_err;
   logic [NUM_SYNAPSE-1:0][NIW-1:0]     r_sel_ip;
   logic [NUM_SYNAPSE-1:0]              r_syn_en;
   logic [NUM_SYNAPSE-1:0]              r_syn_in;
   logic [NUM_SYNAPSE-1:0][SNW-1:0]     r_syn_neuron;

   layer_cfg_t                          w_tab_cur;
   logic [NUM_SYNAPSE-1:0][NIW-1:0]     w_map_sel;
   logic [NUM_SYNAPSE-1:0]              w_map_en;
   logic [NUM_SYNAPSE-1:0]              w_map_in;
   logic [NUM_SYNAPSE-1:0][SNW-1:0]     w_map_neuron;
   logic [NUM_NEURONS-1:0]              w_spk_mask;
   logic [NUM_INPUTS-1:0]               w_x_next;
   logic                                w_idle;
   logic                                w_cfg_ok;
   logic                                w_nl_ok;
   logic                                w_more;
   logic                                w_timeout;

   // Config entry of the layer currently being run.
   assign w_tab_cur = r_tab[r_k[AW-1:0]];

   assign w_idle    = (r_state == ST_IDLE);
   assign w_cfg_ok  = in_range(32'(cfg_ni), NUM_INPUTS) &&
                      in_range(32'(cfg_nn), NUM_NEURONS) &&
                      (32'(cfg_addr) < NUM_LAYERS);
   assign w_nl_ok   = in_range(32'(num_layers), NUM_LAYERS);
   assign w_more    = ((r_k + NLW'(1)) < r_nl);
   assign w_timeout = (r_state == ST_WAIT) && !arr_done && (r_wd == WDW'(TIMEOUT - 1));

   syn_map #(
      .NUM_INPUTS  (NUM_INPUTS),
      .NUM_NEURONS (NUM_NEURONS),
      .NUM_SYNAPSE (NUM_SYNAPSE)
   ) u_syn_map (
      .i_ni         (w_tab_cur.ni),
      .i_nn         (w_tab_cur.nn),
      .i_x_cur      (r_x_cur),
      .o_sel_ip     (w_map_sel),
      .o_syn_en     (w_map_en),
      .o_syn_in     (w_map_in),
      .o_syn_neuron (w_map_neuron)
   );

   // Keep only the spikes of neurons that exist in the current layer.
   always_comb begin
      w_spk_mask = '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (i < int'(r_cur_nn)) begin
            w_spk_mask[i] = arr_spikes[i];
         end
      end
   end

   // Next-layer input vector: neuron spikes, zero-padded to the input width.
   always_comb begin
      w_x_next = '0;
      for (int i = 0; i < XN; i++) begin
         w_x_next[i] = w_spk_mask[i];
      end
   end

   // Config table writes (idle only) and the sticky configuration error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_tab[i].ni <= CFG_W'(NUM_INPUTS);
            r_tab[i].nn <= CFG_W'(NUM_NEURONS);
         end
         r_cfg_err <= 1'b0;
      end else begin
         if (w_idle && cfg_we) begin
            if (w_cfg_ok) begin
               r_tab[cfg_addr].ni <= CFG_W'(cfg_ni);
               r_tab[cfg_addr].nn <= CFG_W'(cfg_nn);
            end else begin
               r_cfg_err <= 1'b1;
            end
         end
         if (w_idle && start && !w_nl_ok) begin
            r_cfg_err <= 1'b1;
         end
      end
   end

   // Run sequencing: layer index, current input vector, watchdog and result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_k      <= '0;
         r_nl     <= '0;
         r_x_cur  <= '0;
         r_cur_nn <= '0;
         r_wd     <= '0;
         r_y_out  <= '0;
         r_to_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && w_nl_ok) begin
                  r_x_cur <= x_in;
                  r_k     <= '0;
                  r_nl    <= num_layers;
                  r_state <= ST_MAP;
               end
            end
            ST_MAP: begin
               r_cur_nn <= w_tab_cur.nn;
               r_state  <= ST_FIRE;
            end
            ST_FIRE: begin
               r_wd    <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (arr_done) begin
                  if (w_more) begin
                     r_x_cur <= w_x_next;
                     r_k     <= r_k + NLW'(1);
                     r_state <= ST_MAP;
                  end else begin
                     r_y_out <= w_spk_mask;
                     r_state <= ST_DONE;
                  end
               end else if (w_timeout) begin
                  r_to_err <= 1'b1;
                  r_state  <= ST_IDLE;
               end else begin
                  r_wd <= r_wd + WDW'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Synapse mapping registers: loaded in MAP, parked on watchdog expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_ip     <= SEL_IDLE;
         r_syn_en     <= '0;
         r_syn_in     <= '0;
         r_syn_neuron <= '0;
      end else if (r_state == ST_MAP) begin
         r_sel_ip     <= w_map_sel;
         r_syn_en     <= w_map_en;
         r_syn_in     <= w_map_in;
         r_syn_neuron <= w_map_neuron;
      end else if (w_timeout) begin
         r_sel_ip     <= SEL_IDLE;
         r_syn_en     <= '0;
         r_syn_in     <= '0;
         r_syn_neuron <= '0;
      end
   end

   assign sel_ip      = r_sel_ip;
   assign syn_en      = r_syn_en;
   assign syn_in      = r_syn_in;
   assign syn_neuron  = r_syn_neuron;
   assign arr_start   = (r_state == ST_FIRE);
   assign busy        = !w_idle;
   assign y_valid     = (r_state == ST_DONE);
   assign y_out       = r_y_out;
   assign cfg_err     = r_cfg_err;
   assign timeout_err = r_to_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed scenarios plus randomized
// runs, checked against a layer-by-layer model of the mapping and spike flow.
module tb_layer_sequencer;
   import recon_pkg::*;

   localparam int NI = 4;
   localparam int NN = 4;
   localparam int NS = 16;
   localparam int NL = 4;
   localparam int TO = 8;

   // ---------------- clock / reset / DUT ----------------
   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cfg_we;
   logic [1:0]           cfg_addr;
   logic [2:0]           cfg_ni;
   logic [2:0]           cfg_nn;
   logic [2:0]           num_layers;
   logic                 start;
   logic [NI-1:0]        x_in;
   logic [NS-1:0][2:0]   sel_ip;
   logic [NS-1:0]        syn_en;
   logic [NS-1:0]        syn_in;
   logic [NS-1:0][1:0]   syn_neuron;
   logic                 arr_start;
   logic                 arr_done;
   logic [NN-1:0]        arr_spikes;
   logic                 busy;
   logic                 y_valid;
   logic [NN-1:0]        y_out;
   logic                 cfg_err;
   logic                 timeout_err;
   logic [STATE_W-1:0]   dbg_state;

   always #5 clk = ~clk;

   layer_sequencer #(
      .NUM_INPUTS (NI), .NUM_NEURONS (NN), .NUM_SYNAPSE (NS),
      .NUM_LAYERS (NL), .TIMEOUT (TO)
   ) dut (
      .clk (clk), .rst (rst),
      .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_ni (cfg_ni), .cfg_nn (cfg_nn),
      .num_layers (num_layers), .start (start), .x_in (x_in),
      .sel_ip (sel_ip), .syn_en (syn_en), .syn_in (syn_in), .syn_neuron (syn_neuron),
      .arr_start (arr_start), .arr_done (arr_done), .arr_spikes (arr_spikes),
      .busy (busy), .y_valid (y_valid), .y_out (y_out),
      .cfg_err (cfg_err), .timeout_err (timeout_err), .dbg_state (dbg_state)
   );

   // ---------------- bench state / model ----------------
   int                   n_tests = 0;
   int                   n_fail  = 0;
   int                   tb_ni [NL];
   int                   tb_nn [NL];
   logic                 exp_cfg_err;
   logic                 exp_to_err;
   int                   drv_dly [NL];
   logic [NN-1:0]        drv_spk [NL];
   int                   abort_layer;
   int                   n_starts;
   logic                 fire_glitch;
   logic                 busy_cfg;
   logic [NS-1:0]        cap_en  [NL];
   logic [NS-1:0][2:0]   cap_sel [NL];
   logic [NS-1:0][2:0]   sel_idle;
   logic [NN-1:0]        exp_q [$];

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin
         tb_ni[i] = NI;
         tb_nn[i] = NN;
      end
      exp_cfg_err = 1'b0;
      exp_to_err  = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_ni = '0; cfg_nn = '0;
      num_layers = '0; start = 1'b0; x_in = '0; arr_done = 1'b0; arr_spikes = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic cfg_write(input int a, input int ni, input int nn);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 2'(a); cfg_ni = 3'(ni); cfg_nn = 3'(nn);
      @(negedge clk);
      cfg_we = 1'b0;
      if (ni >= 1 && ni <= NI && nn >= 1 && nn <= NN) begin
         tb_ni[a] = ni;
         tb_nn[a] = nn;
      end else begin
         exp_cfg_err = 1'b1;
      end
   endtask

   // One complete run: per layer the expected mapping is built by enumerating
   // (neuron, input) pairs, and the masked spikes are fed forward as inputs.
   task automatic do_run(input int nl, input logic [NI-1:0] x);
      logic [NI-1:0]      xc;
      logic [NN-1:0]      spk;
      logic [NN-1:0]      e_y;
      logic [NS-1:0]      e_en;
      logic [NS-1:0]      e_in;
      logic [NS-1:0][2:0] e_sel;
      logic [NS-1:0][1:0] e_nrn;
      int                 cyc;
      int                 m;
      int                 vcount;
      n_starts = 0;
      exp_q.delete();
      xc = x;
      @(negedge clk);
      start = 1'b1; num_layers = 3'(nl); x_in = x;
      @(negedge clk);
      start = 1'b0; num_layers = 3'($urandom_range(0, 7)); x_in = NI'($urandom);
      for (int k = 0; k < nl; k++) begin
         e_en = '0; e_in = '0; e_nrn = '0;
         for (int s = 0; s < NS; s++) e_sel[s] = 3'(NI);
         for (int n = 0; n < tb_nn[k]; n++) begin
            for (int i = 0; i < tb_ni[k]; i++) begin
               m        = n * tb_ni[k] + i;
               e_en[m]  = 1'b1;
               e_sel[m] = 3'(i);
               e_nrn[m] = 2'(n);
               e_in[m]  = xc[i];
            end
         end
         cyc = 0;
         while (arr_start !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         n_tests++;
         if (arr_start !== 1'b1) begin
            n_fail++;
            $display("FAIL arr_start_wait layer %0d: arr_start=%b required 1 within 20 cycles", k, arr_start);
            return;
         end
         n_starts++;
         cap_en[k]  = syn_en;
         cap_sel[k] = sel_ip;
         n_tests++;
         if (syn_en !== e_en) begin
            n_fail++; $display("FAIL syn_en layer %0d: got %h required %h", k, syn_en, e_en);
         end
         n_tests++;
         if (sel_ip !== e_sel) begin
            n_fail++; $display("FAIL sel_ip layer %0d: got %h required %h", k, sel_ip, e_sel);
         end
         n_tests++;
         if (syn_neuron !== e_nrn) begin
            n_fail++; $display("FAIL syn_neuron layer %0d: got %h required %h", k, syn_neuron, e_nrn);
         end
         n_tests++;
         if (syn_in !== e_in) begin
            n_fail++; $display("FAIL syn_in layer %0d: got %h required %h", k, syn_in, e_in);
         end
         if (fire_glitch) begin
            arr_done = 1'b1; arr_spikes = '1;
         end
         @(negedge clk);
         arr_done = 1'b0;
         n_tests++;
         if (arr_start !== 1'b0) begin
            n_fail++; $display("FAIL arr_start_width layer %0d: got %b required 0", k, arr_start);
         end
         if (k == abort_layer) begin
            #2 rst = 1'b1;
            #1;
            n_tests++;
            if ({busy, arr_start, y_valid, cfg_err, timeout_err} !== 5'b0) begin
               n_fail++;
               $display("FAIL abort_ctrl: busy/arr_start/y_valid/cfg_err/timeout_err=%b required 00000",
                        {busy, arr_start, y_valid, cfg_err, timeout_err});
            end
            n_tests++;
            if ({y_out, syn_en, syn_in, syn_neuron} !== '0 || sel_ip !== sel_idle) begin
               n_fail++;
               $display("FAIL abort_data: y_out=%h syn_en=%h syn_in=%h syn_neuron=%h sel_ip=%h required 0/0/0/0/%h",
                        y_out, syn_en, syn_in, syn_neuron, sel_ip, sel_idle);
            end
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            return;
         end
         if (busy_cfg && k == 0) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_ni = 3'd1; cfg_nn = 3'd1;
            @(negedge clk);
            cfg_ni = 3'd0;
            @(negedge clk);
            cfg_we = 1'b0;
            for (int j = 3; j < drv_dly[k]; j++) @(negedge clk);
         end else begin
            for (int j = 1; j < drv_dly[k]; j++) @(negedge clk);
         end
         spk = drv_spk[k];
         arr_done = 1'b1; arr_spikes = spk;
         xc = spk & NN'((1 << tb_nn[k]) - 1);
         if (k == nl - 1) exp_q.push_back(xc);
         @(negedge clk);
         arr_done = 1'b0; arr_spikes = NN'($urandom);
      end
      vcount = 0;
      for (int j = 0; j < 4; j++) begin
         if (y_valid === 1'b1) begin
            vcount++;
            if (exp_q.size() > 0) begin
               e_y = exp_q.pop_front();
               n_tests++;
               if (y_out !== e_y) begin
                  n_fail++; $display("FAIL y_out: got %b required %b", y_out, e_y);
               end
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (vcount !== 1) begin
         n_fail++; $display("FAIL y_valid_count: got %0d required 1", vcount);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL busy_after_run: got %b required 0", busy);
      end
      n_tests++;
      if (y_out !== xc) begin
         n_fail++; $display("FAIL y_out_hold: got %b required %b", y_out, xc);
      end
      n_tests++;
      if (n_starts !== nl) begin
         n_fail++; $display("FAIL arr_start_count: got %0d required %0d", n_starts, nl);
      end
      n_tests++;
      if (cfg_err !== exp_cfg_err || timeout_err !== exp_to_err) begin
         n_fail++;
         $display("FAIL sticky_errs: cfg_err=%b timeout_err=%b required %b %b",
                  cfg_err, timeout_err, exp_cfg_err, exp_to_err);
      end
   endtask

   task automatic rand_drive(input int nl);
      for (int k = 0; k < NL; k++) begin
         drv_dly[k] = $urandom_range(1, 5);
         drv_spk[k] = NN'($urandom);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({busy, arr_start, y_valid, cfg_err, timeout_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy/arr_start/y_valid/cfg_err/timeout_err=%b required 00000",
                  {busy, arr_start, y_valid, cfg_err, timeout_err});
      end
      n_tests++;
      if (y_out !== '0) begin
         n_fail++; $display("FAIL reset_y_out: got %b required 0", y_out);
      end
      n_tests++;
      if (syn_en !== '0 || syn_in !== '0 || syn_neuron !== '0) begin
         n_fail++; $display("FAIL reset_syn: en=%h in=%h neuron=%h required 0", syn_en, syn_in, syn_neuron);
      end
      n_tests++;
      if (sel_ip !== sel_idle) begin
         n_fail++; $display("FAIL reset_sel_ip: got %h required %h", sel_ip, sel_idle);
      end
      // default table is 4x4 on every entry
      rand_drive(3);
      do_run(3, NI'($urandom));
   endtask

   task automatic test_single_layer();
      do_reset();
      cfg_write(0, 4, 4);
      drv_dly[0] = 3;
      drv_spk[0] = 4'b0110;
      do_run(1, 4'b1010);
      n_tests++;
      if (cap_en[0] !== 16'hFFFF) begin
         n_fail++; $display("FAIL single_syn_en: got %h required ffff", cap_en[0]);
      end
      n_tests++;
      if (cap_sel[0][5] !== 3'd1) begin
         n_fail++; $display("FAIL single_sel_ip5: got %0d required 1", cap_sel[0][5]);
      end
      n_tests++;
      if (y_out !== 4'b0110) begin
         n_fail++; $display("FAIL single_y_out: got %b required 0110", y_out);
      end
   endtask

   task automatic test_two_layer();
      do_reset();
      cfg_write(0, 3, 2);
      cfg_write(1, 2, 3);
      rand_drive(2);
      fire_glitch = 1'b1;
      do_run(2, NI'($urandom));
      fire_glitch = 1'b0;
      n_tests++;
      if (cap_en[0] !== 16'h003F || cap_en[1] !== 16'h003F) begin
         n_fail++; $display("FAIL two_syn_en: got %h %h required 003f 003f", cap_en[0], cap_en[1]);
      end
      n_tests++;
      if (cap_sel[0][6] !== 3'd4) begin
         n_fail++; $display("FAIL two_sel_ip6: got %0d required 4", cap_sel[0][6]);
      end
   endtask

   task automatic test_cfg_err();
      do_reset();
      cfg_write(0, 0, 2);
      n_tests++;
      if (cfg_err !== 1'b1) begin
         n_fail++; $display("FAIL cfg_ni0_err: got %b required 1", cfg_err);
      end
      do_reset();
      cfg_write(1, 2, 5);
      n_tests++;
      if (cfg_err !== 1'b1) begin
         n_fail++; $display("FAIL cfg_nn5_err: got %b required 1", cfg_err);
      end
      rand_drive(2);
      do_run(2, NI'($urandom));
      for (int bad = 0; bad < 2; bad++) begin
         do_reset();
         @(negedge clk);
         start = 1'b1; num_layers = (bad == 0) ? 3'd0 : 3'd5;
         @(negedge clk);
         start = 1'b0;
         n_tests++;
         if (busy !== 1'b0 || cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL bad_start %0d: busy=%b cfg_err=%b required 0 1", bad, busy, cfg_err);
         end
      end
      do_reset();
      rand_drive(2);
      drv_dly[0] = 4;
      busy_cfg   = 1'b1;
      do_run(2, NI'($urandom));
      busy_cfg   = 1'b0;
      rand_drive(1);
      do_run(1, NI'($urandom));
   endtask

   task automatic test_timeout();
      int cyc;
      int cnt;
      int vseen;
      do_reset();
      @(negedge clk);
      start = 1'b1; num_layers = 3'd1; x_in = NI'($urandom);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (arr_start !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (arr_start !== 1'b1) begin
         n_fail++; $display("FAIL to_arr_start: got %b required 1", arr_start);
      end
      cnt = 0;
      vseen = 0;
      @(negedge clk);
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         if (y_valid === 1'b1) vseen++;
         @(negedge clk);
      end
      exp_to_err = 1'b1;
      n_tests++;
      if (cnt !== TO) begin
         n_fail++; $display("FAIL to_wait_cycles: got %0d required %0d", cnt, TO);
      end
      n_tests++;
      if (timeout_err !== 1'b1 || vseen !== 0 || y_valid !== 1'b0) begin
         n_fail++; $display("FAIL to_flags: timeout_err=%b y_valid_pulses=%0d required 1 0", timeout_err, vseen);
      end
      n_tests++;
      if (syn_en !== '0 || syn_in !== '0 || sel_ip !== sel_idle) begin
         n_fail++; $display("FAIL to_mapping: en=%h in=%h sel=%h required 0 0 %h", syn_en, syn_in, sel_ip, sel_idle);
      end
      rand_drive(1);
      do_run(1, NI'($urandom));
   endtask

   task automatic test_reset_midrun();
      int vseen;
      do_reset();
      cfg_write(0, 3, 2);
      cfg_write(1, 2, 3);
      rand_drive(2);
      abort_layer = 1;
      do_run(2, NI'($urandom));
      abort_layer = -1;
      vseen = 0;
      for (int j = 0; j < 6; j++) begin
         if (y_valid === 1'b1 || busy === 1'b1) vseen++;
         @(negedge clk);
      end
      n_tests++;
      if (vseen !== 0) begin
         n_fail++; $display("FAIL abort_quiet: busy/y_valid cycles=%0d required 0", vseen);
      end
      rand_drive(2);
      do_run(2, NI'($urandom));
   endtask

   task automatic test_random();
      do_reset();
      for (int it = 0; it < 12; it++) begin
         for (int w = 0; w < 2; w++) begin
            cfg_write($urandom_range(0, NL - 1), $urandom_range(0, NI + 1), $urandom_range(0, NN + 1));
         end
         rand_drive(NL);
         fire_glitch = 1'($urandom_range(0, 1));
         do_run($urandom_range(1, NL), NI'($urandom));
      end
      fire_glitch = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int s = 0; s < NS; s++) sel_idle[s] = 3'(NI);
      fire_glitch = 1'b0;
      busy_cfg    = 1'b0;
      abort_layer = -1;
      model_reset();
      test_reset();
      test_single_layer();
      test_two_layer();
      test_cfg_err();
      test_timeout();
      test_reset_midrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
